// File: rtl/ntt_intt_core_if.sv
// rtl/ntt_intt_core_if.sv - transform request/result handshake bundle for ntt_intt_core
interface ntt_intt_core_if #(
   parameter int N = 17,
   parameter int D = 8
);
   logic           in_valid;
   logic           in_ready;
   logic           mode;
   logic [D*N-1:0] a;
   logic [D*N-1:0] tw_fwd;
   logic [D*N-1:0] tw_inv;
   logic           out_valid;
   logic           out_ready;
   logic [D*N-1:0] b;

   modport master (
      output in_valid, mode, a, tw_fwd, tw_inv, out_ready,
      input  in_ready, out_valid, b
   );

   modport slave (
      input  in_valid, mode, a, tw_fwd, tw_inv, out_ready,
      output in_ready, out_valid, b
   );
endinterface

// File: rtl/ntt_intt_core.sv
// rtl/ntt_intt_core.sv - iterative negacyclic NTT/INTT, one full butterfly stage per cycle
// Forward uses Cooley-Tukey with bit-reversed twiddles, inverse uses Gentleman-Sande plus D^-1 scaling.
module ntt_intt_core #(
   parameter int N    = 17,
   parameter int D    = 8,
   parameter int Q    = 12289,
   parameter int NINV = 10753
) (
   input logic          clk,
   input logic          rst,
   ntt_intt_core_if.slave io
);
   localparam int L = $clog2(D);

   typedef logic [L-1:0] idx_t;
   typedef logic [N-1:0] coef_t;
   typedef enum logic [1:0] {IDLE, RUN, SCALE, OUT} state_t;

   localparam logic [N:0]     QN     = (N+1)'(Q);
   localparam logic [2*N-1:0] QW     = (2*N)'(Q);
   localparam coef_t          NINV_C = N'(NINV);

   state_t state_q, state_d;
   idx_t   stage_q;
   logic   mode_q;
   logic   last_stage;

   coef_t work_q  [D];
   coef_t stage_d [D];
   coef_t scale_d [D];
   coef_t a_in    [D];
   coef_t tw_f    [D];
   coef_t tw_i    [D];

   idx_t  bf_j  [D/2];
   idx_t  bf_jt [D/2];
   coef_t bf_x  [D/2];
   coef_t bf_y  [D/2];

   function automatic coef_t mod_add(input coef_t x, input coef_t y);
      logic [N:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (s >= QN) s = s - QN;
      return s[N-1:0];
   endfunction

   function automatic coef_t mod_sub(input coef_t x, input coef_t y);
      logic [N:0] s;
      s = {1'b0, x} - {1'b0, y};
      if (x < y) s = s + QN;
      return s[N-1:0];
   endfunction

   function automatic coef_t mod_mul(input coef_t x, input coef_t y);
      logic [2*N-1:0] p;
      p = {{N{1'b0}}, x} * {{N{1'b0}}, y};
      p = p % QW;
      return p[N-1:0];
   endfunction

   for (genvar k = 0; k < D; k++) begin : g_lane
      assign a_in[k]            = io.a[k*N +: N];
      assign tw_f[k]            = io.tw_fwd[k*N +: N];
      assign tw_i[k]            = io.tw_inv[k*N +: N];
      assign io.b[k*N +: N]     = work_q[k];
      assign scale_d[k]         = mod_mul(work_q[k], NINV_C);
   end

   // Butterfly p of the current stage: gs is log2 of the half-span t, grp the twiddle group index.
   for (genvar p = 0; p < D/2; p++) begin : g_bf
      idx_t  gs, grp, jj, jt, slot;
      coef_t u, v, mul_a, mul_w, prod, x, y;

      always_comb begin
         gs    = mode_q ? stage_q : idx_t'(L-1) - stage_q;
         grp   = idx_t'(p) >> gs;
         jj    = ((grp << gs) << 1) | (idx_t'(p) & ((idx_t'(1) << gs) - idx_t'(1)));
         jt    = jj | (idx_t'(1) << gs);
         slot  = (idx_t'(1) << (idx_t'(L-1) - gs)) + grp;
         u     = work_q[jj];
         v     = work_q[jt];
         mul_a = mode_q ? mod_sub(u, v) : v;
         mul_w = mode_q ? tw_i[slot] : tw_f[slot];
         prod  = mod_mul(mul_a, mul_w);
         x     = mode_q ? mod_add(u, v) : mod_add(u, prod);
         y     = mode_q ? prod : mod_sub(u, prod);
      end

      assign bf_j[p]  = jj;
      assign bf_jt[p] = jt;
      assign bf_x[p]  = x;
      assign bf_y[p]  = y;
   end

   always_comb begin
      for (int k = 0; k < D; k++) stage_d[k] = work_q[k];
      for (int p = 0; p < D/2; p++) begin
         stage_d[bf_j[p]]  = bf_x[p];
         stage_d[bf_jt[p]] = bf_y[p];
      end
   end

   // in_ready is gated by rst so it stays low for as long as reset is held.
   always_comb begin
      state_d      = state_q;
      io.in_ready  = 1'b0;
      io.out_valid = 1'b0;
      last_stage   = (stage_q == idx_t'(L-1));
      case (state_q)
         IDLE: begin
            io.in_ready = rst;
            if (io.in_valid) state_d = RUN;
         end
         RUN: begin
            if (last_stage) state_d = mode_q ? SCALE : OUT;
         end
         SCALE: state_d = OUT;
         OUT: begin
            io.out_valid = 1'b1;
            if (io.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         stage_q <= '0;
         mode_q  <= 1'b0;
         for (int k = 0; k < D; k++) work_q[k] <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (io.in_valid) begin
                  mode_q  <= io.mode;
                  stage_q <= '0;
                  for (int k = 0; k < D; k++) work_q[k] <= a_in[k];
               end
            end
            RUN: begin
               stage_q <= last_stage ? '0 : stage_q + idx_t'(1);
               for (int k = 0; k < D; k++) work_q[k] <= stage_d[k];
            end
            SCALE: begin
               for (int k = 0; k < D; k++) work_q[k] <= scale_d[k];
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_ntt_intt_core.sv
// tb/tb_ntt_intt_core.sv - scoreboard bench for ntt_intt_core against a direct negacyclic NTT model
module tb_ntt_intt_core;
   localparam int N    = 17;
   localparam int D    = 8;
   localparam int Q    = 12289;
   localparam int NINV = 10753;
   localparam int L    = 3;

   typedef logic [D*N-1:0] vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ntt_intt_core_if #(.N(N), .D(D)) io ();

   ntt_intt_core #(.N(N), .D(D), .Q(Q), .NINV(NINV)) dut (
      .clk (clk),
      .rst (rst),
      .io  (io)
   );

   int     tests_run    = 0;
   int     tests_failed = 0;
   vec_t   exp_q [$];
   longint psi;
   longint psi_inv;

   task automatic check_eq(input string tag, input vec_t got, input vec_t exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic longint powmod(input longint base, input longint e);
      longint r, bb, ee;
      r  = 1;
      bb = base % Q;
      ee = e;
      while (ee > 0) begin
         if (ee % 2 == 1) r = (r * bb) % Q;
         bb = (bb * bb) % Q;
         ee = ee / 2;
      end
      return r;
   endfunction

   function automatic int brv(input int k);
      int r = 0;
      for (int i = 0; i < L; i++) if (((k >> i) & 1) == 1) r = r | (1 << (L-1-i));
      return r;
   endfunction

   function automatic longint coef(input vec_t v, input int k);
      return longint'(v[k*N +: N]);
   endfunction

   // Output slot i holds a(x) evaluated at psi^(2*brv(i)+1).
   function automatic vec_t model_fwd(input vec_t av);
      vec_t   r = '0;
      longint acc;
      int     e;
      for (int i = 0; i < D; i++) begin
         acc = 0;
         e   = 2 * brv(i) + 1;
         for (int j = 0; j < D; j++)
            acc = (acc + coef(av, j) * powmod(psi, (e * j) % (2*D))) % Q;
         r[i*N +: N] = N'(acc);
      end
      return r;
   endfunction

   function automatic vec_t const_vec(input int val);
      vec_t r = '0;
      for (int k = 0; k < D; k++) r[k*N +: N] = N'(val);
      return r;
   endfunction

   function automatic vec_t rand_vec();
      vec_t r = '0;
      for (int k = 0; k < D; k++) r[k*N +: N] = N'($urandom_range(0, Q-1));
      return r;
   endfunction

   function automatic logic all_below_q(input vec_t v);
      for (int k = 0; k < D; k++) if (coef(v, k) >= Q) return 1'b0;
      return 1'b1;
   endfunction

   task automatic xfer(input logic m, input vec_t av, input int hold, output vec_t res);
      int   cyc;
      vec_t held;
      io.mode     = m;
      io.a        = av;
      io.in_valid = 1'b1;
      cyc = 0;
      while (!io.in_ready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check_eq("accept", vec_t'(io.in_ready), vec_t'(1));
      @(posedge clk);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            io.in_valid = 1'b0;
            io.mode     = ~m;
            io.a        = rand_vec();
         end
         if (!io.out_valid) check_eq("busy_in_ready", vec_t'(io.in_ready), vec_t'(0));
      end while (!io.out_valid && cyc < 50);
      check_eq(m ? "latency_inv" : "latency_fwd", vec_t'(cyc), vec_t'(m ? L+2 : L+1));
      res = io.b;
      check_eq("sb_nonempty", vec_t'(exp_q.size() > 0), vec_t'(1));
      if (exp_q.size() > 0) check_eq(m ? "result_inv" : "result_fwd", io.b, exp_q.pop_front());
      check_eq("range", vec_t'(all_below_q(io.b)), vec_t'(1));
      held = io.b;
      for (int h = 0; h < hold; h++) begin
         io.in_valid = (h % 2 == 0);
         io.a        = rand_vec();
         @(negedge clk);
         check_eq("hold_b", io.b, held);
         check_eq("hold_out_valid", vec_t'(io.out_valid), vec_t'(1));
         check_eq("hold_in_ready", vec_t'(io.in_ready), vec_t'(0));
      end
      io.in_valid  = 1'b0;
      io.out_ready = 1'b1;
      check_eq("hs_in_ready", vec_t'(io.in_ready), vec_t'(0));
      @(negedge clk);
      io.out_ready = 1'b0;
      check_eq("to_idle", vec_t'({io.in_ready, io.out_valid}), vec_t'(2'b10));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t   av, fv, rv, impulse;
      longint c;
      io.in_valid  = 1'b0;
      io.out_ready = 1'b0;
      io.mode      = 1'b0;
      io.a         = '0;
      io.tw_fwd    = '0;
      io.tw_inv    = '0;
      impulse      = '0;
      impulse[N-1:0] = N'(1);

      psi = 0;
      for (longint x = 2; x < Q && psi == 0; x++) begin
         c = powmod(x, (Q-1) / (2*D));
         if (powmod(c, D) == Q-1) psi = c;
      end
      psi_inv = powmod(psi, 2*D - 1);
      for (int k = 1; k < D; k++) begin
         io.tw_fwd[k*N +: N] = N'(powmod(psi, brv(k)));
         io.tw_inv[k*N +: N] = N'(powmod(psi_inv, brv(k)));
      end

      repeat (3) @(negedge clk);
      check_eq("rst_in_ready", vec_t'(io.in_ready), vec_t'(0));
      check_eq("rst_out_valid", vec_t'(io.out_valid), vec_t'(0));
      check_eq("rst_b", io.b, '0);
      rst = 1'b1;
      @(negedge clk);
      check_eq("rel_in_ready", vec_t'(io.in_ready), vec_t'(1));

      exp_q.push_back(const_vec(1));
      xfer(1'b0, impulse, 0, rv);
      exp_q.push_back(impulse);
      xfer(1'b1, const_vec(1), 0, rv);

      av = rand_vec();
      exp_q.push_back(model_fwd(av));
      xfer(1'b0, av, 10, rv);

      io.a        = rand_vec();
      io.mode     = 1'b0;
      io.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      io.in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_eq("abort_out_valid", vec_t'(io.out_valid), vec_t'(0));
      check_eq("abort_b", io.b, '0);
      check_eq("abort_in_ready", vec_t'(io.in_ready), vec_t'(0));
      rst = 1'b1;
      @(negedge clk);
      exp_q.push_back(const_vec(1));
      xfer(1'b0, impulse, 0, rv);

      for (int n = 0; n < 1000; n++) begin
         if (n == 0)      av = const_vec(Q-1);
         else if (n == 1) av = '0;
         else             av = rand_vec();
         exp_q.push_back(model_fwd(av));
         xfer(1'b0, av, $urandom_range(0, 2), fv);
         exp_q.push_back(av);
         xfer(1'b1, fv, $urandom_range(0, 2), rv);
      end

      check_eq("sb_drained", vec_t'(exp_q.size()), vec_t'(0));
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/ntt_intt_core.md
NTT_INTT_CORE -- requirements
Module: ntt_intt_core

Interface
REQ-001 Parameter N, default 17: coefficient width in bits.
REQ-002 Parameter D, default 8: transform length; power of two, 4..64.
REQ-003 Parameter Q, default 12289: prime modulus; 2 < Q < 2^N; Q ≡ 1 mod 2D.
REQ-004 Parameter NINV, default 10753: D^-1 mod Q, used to scale the inverse result.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 in_valid  input  1  a and mode are presented.
REQ-008 in_ready  output  1  core accepts a transform.
REQ-009 mode  input  1  0 = forward NTT, 1 = inverse NTT; sampled on the accept edge.
REQ-010 a  input  D*N  input coefficients; coefficient k occupies bits [N*(k+1)-1:N*k]; each value < Q.
REQ-011 tw_fwd  input  D*N  forward twiddles psi^brv(k) mod Q in slot k (k=1..D-1); slot 0 ignored; static while busy.
REQ-012 tw_inv  input  D*N  inverse twiddles psi^-brv(k) mod Q in slot k (k=1..D-1); slot 0 ignored; static while busy.
REQ-013 out_valid  output  1  b holds a completed result.
REQ-014 out_ready  input  1  consumer takes b.
REQ-015 b  output  D*N  result coefficients, same packing as a; each value in [0,Q).

Function
REQ-016 The core SHALL implement states IDLE, RUN, SCALE and OUT in an FSM.
REQ-017 IDLE: in_ready=1; in_valid&in_ready SHALL latch a into the D-entry working register, latch mode, clear the stage counter and enter RUN.
REQ-018 RUN SHALL execute one full butterfly stage per cycle (all D/2 butterflies in parallel), for L=log2(D) cycles, with the stage counter counting 0..L-1.
REQ-019 Forward stage s: t=D>>(s+1), m=1<<s; for i<m, j in [2it, 2it+t): w=tw_fwd slot m+i; v=a[j+t]*w mod Q; a[j]=(a[j]+v) mod Q; a[j+t]=(a[j]-v) mod Q (Cooley-Tukey).
REQ-020 Inverse stage s: t=1<<s, m=D>>(s+1); for i<m, j in [2it, 2it+t): w=tw_inv slot m+i; u=a[j], v=a[j+t]; a[j]=(u+v) mod Q; a[j+t]=((u-v) mod Q)*w mod Q (Gentleman-Sande).
REQ-021 Internal arithmetic: add/sub at N+1 bits with one conditional ±Q correction; products at 2N bits reduced fully mod Q; every stored value SHALL be in [0,Q).
REQ-022 After stage L-1, forward mode SHALL go to OUT; inverse mode SHALL go to SCALE.
REQ-023 SCALE SHALL multiply every coefficient by NINV mod Q in one cycle, then go to OUT.
REQ-024 Latency from the accept edge to the first cycle with out_valid=1: L+1 cycles in forward mode, L+2 in inverse mode (D=8: 4 and 5).
REQ-025 OUT: out_valid=1; b SHALL equal the working register and stay stable until out_valid&out_ready; that edge SHALL go to IDLE.
REQ-026 in_ready SHALL be 0 in RUN, SCALE and OUT, including the OUT cycle that completes the handshake; in_valid outside IDLE SHALL be ignored.
REQ-027 out_valid SHALL be 0 outside OUT; out_ready outside OUT SHALL be ignored.
REQ-028 b SHALL show the working register in every state; only the OUT value is defined as a result.
REQ-029 Changes to mode or a after the accept edge SHALL have no effect on the transform in progress.

Reset
REQ-030 rst=0 at a rising edge SHALL force IDLE, stage counter 0, working register 0 (b=0) and out_valid=0, aborting any transform in progress.
REQ-031 While rst=0, in_ready SHALL be 0; in_ready=1 starting with the first cycle after rst returns to 1.

Verification
REQ-032 D=8, Q=12289: forward, a=[1,0,0,0,0,0,0,0] -> out_valid 4 cycles after accept, b all coefficients = 1.
REQ-033 Inverse, a all 1 -> out_valid 5 cycles after accept, b=[1,0,0,0,0,0,0,0].
REQ-034 Round trip on 1000 random vectors, including all-(Q-1) and all-0 -> inverse(forward(a)) == a; every output coefficient < Q; results match a software negacyclic-NTT model.
REQ-035 Hold out_ready=0 for 10 cycles in OUT -> b unchanged, out_valid=1, in_ready=0; pulse in_valid throughout -> nothing accepted; release -> IDLE next cycle.
REQ-036 Assert rst=0 in RUN stage 1 -> next cycle out_valid=0, b=0, in_ready=0; after release -> new forward transform of the impulse yields all 1 with normal latency.
